// File: rtl/ascii_pkg.sv
// Shared ASCII constants, upper-case test and FSM state type for the lower-case stream.
package ascii_pkg;

    localparam logic [7:0]  ASCII_UPPER_A  = 8'h41;
    localparam logic [7:0]  ASCII_UPPER_Z  = 8'h5A;
    localparam int unsigned ASCII_CASE_BIT = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } tl_state_t;

    function automatic logic is_upper(input logic [7:0] b);
        return (b >= ASCII_UPPER_A) && (b <= ASCII_UPPER_Z);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit so full/empty need no counter.
module byte_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage is cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
                wr_ptr_q                <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/tolower_stream.sv
// Streaming ASCII lower-caser with buffered output, enable/drain FSM and a
// saturating count of converted bytes.
module tolower_stream
    import ascii_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_changed,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] conv_count
);

    localparam logic [7:0] CASE_MASK = 8'(1) << ASCII_CASE_BIT;

    tl_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic [8:0]       fifo_head;
    logic [8:0]       fifo_wdata;
    logic             push;
    logic             pop;
    logic             upper;

    assign upper      = is_upper(in_data);
    assign fifo_wdata = upper ? {1'b1, in_data | CASE_MASK} : {1'b0, in_data};

    assign in_ready    = (state_q == RUN) && !fifo_full;
    assign out_valid   = !fifo_empty;
    assign out_changed = fifo_head[8];
    assign out_data    = fifo_head[7:0];
    assign conv_count  = cnt_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Clear takes priority over a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (push && upper && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A byte pushed in the same cycle en falls must still be drained, so only
    // skip DRAIN when the FIFO is empty and nothing is being written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) state_q <= RUN;
                end
                RUN: begin
                    if (!en) begin
                        state_q <= (fifo_empty && !push) ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) state_q <= en ? RUN : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tolower_stream.sv
// Randomized self-checking bench for tolower_stream against a queue-based reference model.
module tb_tolower_stream;
    import ascii_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_changed;
    logic             out_ready = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] conv_count;

    int errors = 0;
    int checks = 0;
    logic [8:0] model_q[$];
    logic [8:0] got_q[$];
    int cnt_m = 0;

    tolower_stream #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_changed (out_changed),
        .out_ready   (out_ready),
        .cnt_clr     (cnt_clr),
        .conv_count  (conv_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference mapping: upper-case letters move up by 32 in the code table.
    function automatic logic [8:0] ref_map(input logic [7:0] b);
        if (b >= 8'd65 && b <= 8'd90) return {1'b1, b + 8'd32};
        return {1'b0, b};
    endfunction

    task automatic step();
        logic psh, pp;
        logic [8:0] exp, mapped;
        psh = in_valid && in_ready;
        pp  = out_valid && out_ready;
        mapped = ref_map(in_data);
        if (pp) begin
            checks++;
            if (model_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got byte %h, required no valid byte", out_data);
            end else begin
                exp = model_q.pop_front();
                if ({out_changed, out_data} !== exp) begin
                    errors++;
                    $display("FAIL pop_data: got %h, required %h", {out_changed, out_data}, exp);
                end
            end
            got_q.push_back({out_changed, out_data});
        end
        if (psh) model_q.push_back(mapped);
        if (cnt_clr) cnt_m = 0;
        else if (psh && mapped[8] && cnt_m < CMAX) cnt_m++;
        @(posedge clk); #1;
        checks++;
        if (conv_count !== CNT_W'(cnt_m)) begin
            errors++;
            $display("FAIL conv_count: got %0d, required %0d", conv_count, cnt_m);
        end
        checks++;
        if (out_valid !== (model_q.size() != 0)) begin
            errors++;
            $display("FAIL out_valid: got %b, required %b", out_valid, model_q.size() != 0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                step();
                in_valid = 1'b0;
                return;
            end
            step();
        end
        in_valid = 1'b0;
        checks++; errors++;
        $display("FAIL send_timeout: byte %h not accepted, required acceptance within 50 cycles", b);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (model_q.size() == 0) break;
            step();
        end
        checks++;
        if (model_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d bytes left, required 0", model_q.size());
        end
    endtask

    task automatic test_reset();
        #1;
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h, required 00", out_data); end
        if (out_changed !== 1'b0) begin errors++; $display("FAIL rst_out_changed: got %b, required 0", out_changed); end
        if (conv_count !== '0) begin errors++; $display("FAIL rst_conv_count: got %0d, required 0", conv_count); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        step();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %b, required 0", in_ready); end
    endtask

    task automatic test_basic();
        string s, e;
        logic chg [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] ec;
        s = "Hello@[Z";
        e = "hello@[z";
        en = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL run_in_ready: got %b, required 1", in_ready); end
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(s[i]);
        drain();
        checks++;
        if (got_q.size() != 8) begin
            errors++;
            $display("FAIL basic_count: got %0d bytes, required 8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                ec = e[i];
                checks++;
                if (got_q[i] !== {chg[i], ec}) begin
                    errors++;
                    $display("FAIL basic_byte%0d: got %h, required %h", i, got_q[i], {chg[i], ec});
                end
            end
        end
        checks++;
        if (conv_count !== 4'd2) begin errors++; $display("FAIL basic_conv: got %0d, required 2", conv_count); end
    endtask

    task automatic test_boundary();
        logic [7:0] ib [5] = '{8'h41, 8'h5A, 8'h40, 8'h5B, 8'hC1};
        logic [8:0] ob [5] = '{9'h161, 9'h17A, 9'h040, 9'h05B, 9'h0C1};
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        got_q.delete();
        for (int i = 0; i < 5; i++) send_byte(ib[i]);
        drain();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== ob[i]) begin
                errors++;
                $display("FAIL boundary_byte%0d: got %h, required %h", i,
                         (i < got_q.size()) ? got_q[i] : 9'h1FF, ob[i]);
            end
        end
        checks++;
        if (conv_count !== 4'd2) begin errors++; $display("FAIL boundary_conv: got %0d, required 2", conv_count); end
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        out_ready = 1'b0;
        got_q.delete();
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 8'($urandom);
            if (!in_ready) break;
            step();
            accepted++;
        end
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom);
            step();
            checks += 2;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b, required 0", in_ready); end
            if ({out_changed, out_data} !== model_q[0]) begin
                errors++;
                $display("FAIL stall_head: got %h, required %h", {out_changed, out_data}, model_q[0]);
            end
        end
        in_valid = 1'b0;
        checks++;
        if (accepted != DEPTH) begin errors++; $display("FAIL fill_count: got %0d, required %0d", accepted, DEPTH); end
        out_ready = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop: got %b, required 1", in_ready); end
        drain();
        checks++;
        if (got_q.size() != DEPTH) begin errors++; $display("FAIL drain_count: got %0d, required %0d", got_q.size(), DEPTH); end
    endtask

    task automatic check_state(input string tag, input tl_state_t exp, input logic exp_rdy);
        checks += 2;
        if (dut.state_q !== exp) begin errors++; $display("FAIL %s_state: got %0d, required %0d", tag, dut.state_q, exp); end
        if (in_ready !== exp_rdy) begin errors++; $display("FAIL %s_in_ready: got %b, required %b", tag, in_ready, exp_rdy); end
    endtask

    task automatic test_en_drain();
        got_q.delete();
        out_ready = 1'b0;
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        en = 1'b0;
        step();
        check_state("drop_en", DRAIN, 1'b0);
        drain();
        step();
        check_state("drained", IDLE, 1'b0);
        checks++;
        if (got_q.size() != 2) begin errors++; $display("FAIL en_drain_count: got %0d, required 2", got_q.size()); end
        en = 1'b1;
        step();
        check_state("rerun", RUN, 1'b1);
        out_ready = 1'b0;
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        check_state("en_in_drain", DRAIN, 1'b0);
        drain();
        step();
        check_state("back_to_run", RUN, 1'b1);
    endtask

    task automatic test_saturate();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) send_byte(8'(65 + $urandom_range(0, 25)));
        checks++;
        if (conv_count !== 4'd15) begin errors++; $display("FAIL saturate: got %0d, required 15", conv_count); end
        cnt_clr = 1'b1;
        send_byte(8'(65 + $urandom_range(0, 25)));
        cnt_clr = 1'b0;
        checks++;
        if (conv_count !== 4'd0) begin errors++; $display("FAIL clr_wins: got %0d, required 0", conv_count); end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 30) == 0);
            step();
        end
        en = 1'b1;
        in_valid = 1'b0;
        cnt_clr = 1'b0;
        drain();
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        out_ready = 1'b0;
        step();
        send_byte(8'h51);
        send_byte(8'h52);
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid: got %b, required 0", out_valid); end
        if (conv_count !== '0) begin errors++; $display("FAIL async_conv: got %0d, required 0", conv_count); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL async_in_ready: got %b, required 0", in_ready); end
        if (out_data !== 8'h00) begin errors++; $display("FAIL async_out_data: got %h, required 00", out_data); end
        model_q.delete();
        cnt_m = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        step();
        got_q.delete();
        send_byte(8'h4B);
        drain();
        step();
        step();
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 9'h16B) begin
            errors++;
            $display("FAIL post_reset_output: got %0d bytes, required exactly one 16b", got_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_backpressure();
        test_en_drain();
        test_saturate();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
